// File: rtl/piso_shift_reg.sv
// piso_shift_reg: parameterised parallel-in, serial-out shift register.
//
// A word is captured on load and presented one bit per shift_en cycle on
// serial_out, LSB first by default or MSB first when MSB_FIRST = 1.
// busy stays high while loaded bits remain, and done pulses for one cycle
// after the last loaded bit has been shifted out.
//
// Parameters:
//   N          data width (N >= 2)
//   MSB_FIRST  0: shift right, serial_out = reg[0]; 1: shift left, serial_out = reg[N-1]
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-high reset
//   load        capture I (priority over shift_en)
//   I           parallel data word
//   shift_en    shift one position toward the output end
//   serial_in   fill bit for shifts (only when PISO_SERIAL_IN_EN is defined)
//   serial_out  output end bit of the register
//   busy        loaded bits remain to be shifted out
//   done        one-cycle pulse after the final loaded bit leaves
//   count       loaded bits still to present, including the one on serial_out
//
// Optional feature macro: PISO_SERIAL_IN_EN (adds serial_in; otherwise fill is 0).

module piso_shift_reg #(
   parameter int N         = 4,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   load,
   input  logic [N-1:0]           I,
   input  logic                   shift_en,
`ifdef PISO_SERIAL_IN_EN
   input  logic                   serial_in,
`endif
   output logic                   serial_out,
   output logic                   busy,
   output logic                   done,
   output logic [$clog2(N+1)-1:0] count
);

   localparam int CW = $clog2(N+1);

   logic [N-1:0]  sreg_q, sreg_d;
   logic [CW-1:0] count_q, count_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          fill;

`ifdef PISO_SERIAL_IN_EN
   assign fill = serial_in;
`else
   assign fill = 1'b0;
`endif

   always_comb begin
      sreg_d  = sreg_q;
      count_d = count_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      if (load) begin
         // A load while busy simply restarts; the aborted word gets no done.
         sreg_d  = I;
         count_d = CW'(N);
         busy_d  = 1'b1;
      end else if (shift_en) begin
         if (MSB_FIRST) begin
            sreg_d = {sreg_q[N-2:0], fill};
         end else begin
            sreg_d = {fill, sreg_q[N-1:1]};
         end

         // With count at 0 the register keeps draining but status is frozen.
         if (count_q > CW'(1)) begin
            count_d = count_q - CW'(1);
         end else if (count_q == CW'(1)) begin
            count_d = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sreg_q  <= '0;
         count_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         sreg_q  <= sreg_d;
         count_q <= count_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign serial_out = MSB_FIRST ? sreg_q[N-1] : sreg_q[0];
   assign busy       = busy_q;
   assign done       = done_q;
   assign count      = count_q;

endmodule

// File: tb/tb_piso_shift_reg.sv
// Directed bench for piso_shift_reg: one LSB-first and one MSB-first instance
// (N = 4) share the stimulus. Status is compared as {serial_out, busy, done, count}.

module tb_piso_shift_reg;

   localparam int N  = 4;
   localparam int CW = 3;

   logic          clk;
   logic          reset;
   logic          load;
   logic [N-1:0]  I;
   logic          shift_en;
   logic          serial_in;

   logic          so_a, busy_a, done_a;
   logic [CW-1:0] cnt_a;
   logic          so_b, busy_b, done_b;
   logic [CW-1:0] cnt_b;

   logic [5:0]    st_a, st_b;
   assign st_a = {so_a, busy_a, done_a, cnt_a};
   assign st_b = {so_b, busy_b, done_b, cnt_b};

   int checks;
   int failures;

   piso_shift_reg #(.N(N), .MSB_FIRST(1'b0)) dut_lsb (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .I          (I),
      .shift_en   (shift_en),
`ifdef PISO_SERIAL_IN_EN
      .serial_in  (serial_in),
`endif
      .serial_out (so_a),
      .busy       (busy_a),
      .done       (done_a),
      .count      (cnt_a)
   );

   piso_shift_reg #(.N(N), .MSB_FIRST(1'b1)) dut_msb (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .I          (I),
      .shift_en   (shift_en),
`ifdef PISO_SERIAL_IN_EN
      .serial_in  (serial_in),
`endif
      .serial_out (so_b),
      .busy       (busy_b),
      .done       (done_b),
      .count      (cnt_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      // Reset held across an edge with load high: reset must win.
      reset = 1'b1; load = 1'b1; I = 4'b1111; shift_en = 1'b0;
      tick();
      checks++;
      if (st_a !== 6'b000000) begin failures++; $display("FAIL reset_wins_lsb got=%b exp=%b", st_a, 6'b000000); end
      checks++;
      if (st_b !== 6'b000000) begin failures++; $display("FAIL reset_wins_msb got=%b exp=%b", st_b, 6'b000000); end
      #2 reset = 1'b0; load = 1'b0;
      tick();
      tick();
      checks++;
      if (st_a !== 6'b000000) begin failures++; $display("FAIL reset_release_idle got=%b exp=%b", st_a, 6'b000000); end
      load = 1'b1; I = 4'b1111;
      tick();
      load = 1'b0;
      checks++;
      if (st_a !== 6'b110100) begin failures++; $display("FAIL reset_pre_load got=%b exp=%b", st_a, 6'b110100); end
      // Assert reset mid-period; outputs must clear before the next edge.
      #3 reset = 1'b1;
      #1;
      checks++;
      if (st_a !== 6'b000000) begin failures++; $display("FAIL reset_async_lsb got=%b exp=%b", st_a, 6'b000000); end
      checks++;
      if (st_b !== 6'b000000) begin failures++; $display("FAIL reset_async_msb got=%b exp=%b", st_b, 6'b000000); end
      #1 reset = 1'b0;
      tick();
      checks++;
      if (st_a !== 6'b000000) begin failures++; $display("FAIL reset_after_release got=%b exp=%b", st_a, 6'b000000); end
   endtask

   task automatic test_lsb_word();
      logic [5:0] exp [6] = '{6'b110100, 6'b110011, 6'b010010, 6'b110001, 6'b001000, 6'b000000};
      load = 1'b1; I = 4'b1011;
      tick();
      load = 1'b0; shift_en = 1'b1;
      for (int k = 0; k < 6; k++) begin
         if (k == 2) I = 4'b0100;  // not a load edge: must be ignored
         checks++;
         if (st_a !== exp[k]) begin failures++; $display("FAIL lsb_word step=%0d got=%b exp=%b", k, st_a, exp[k]); end
         if (k < 5) tick();
      end
      shift_en = 1'b0;
   endtask

   task automatic test_msb_word();
      logic [5:0] exp [5] = '{6'b110100, 6'b010011, 6'b010010, 6'b010001, 6'b001000};
      load = 1'b1; I = 4'b1000;
      tick();
      load = 1'b0; shift_en = 1'b1;
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (st_b !== exp[k]) begin failures++; $display("FAIL msb_word step=%0d got=%b exp=%b", k, st_b, exp[k]); end
         if (k < 4) tick();
      end
      shift_en = 1'b0;
      tick();
      checks++;
      if (st_b !== 6'b000000) begin failures++; $display("FAIL msb_done_clear got=%b exp=%b", st_b, 6'b000000); end
   endtask

   task automatic test_stall_reload();
      logic [5:0] exp [5] = '{6'b110100, 6'b110011, 6'b110010, 6'b110001, 6'b001000};
      load = 1'b1; I = 4'b0110;
      tick();
      load = 1'b0;
      checks++;
      if (st_a !== 6'b010100) begin failures++; $display("FAIL stall_load got=%b exp=%b", st_a, 6'b010100); end
      shift_en = 1'b1;
      tick();
      shift_en = 1'b0;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (st_a !== 6'b110011) begin failures++; $display("FAIL stall_hold step=%0d got=%b exp=%b", k, st_a, 6'b110011); end
         if (k < 3) tick();
      end
      load = 1'b1; I = 4'b1111; shift_en = 1'b1;
      tick();
      load = 1'b0;
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (st_a !== exp[k]) begin failures++; $display("FAIL reload step=%0d got=%b exp=%b", k, st_a, exp[k]); end
         if (k < 4) tick();
      end
      shift_en = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_shift();
      load = 1'b1; I = 4'b1111;
      tick();
      load = 1'b0; shift_en = 1'b1;
      tick();
      tick();
      checks++;
      if (st_a !== 6'b110010) begin failures++; $display("FAIL midshift_pre got=%b exp=%b", st_a, 6'b110010); end
      #3 reset = 1'b1;
      #1;
      checks++;
      if (st_a !== 6'b000000) begin failures++; $display("FAIL midshift_async got=%b exp=%b", st_a, 6'b000000); end
      #1 reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (st_a !== 6'b000000) begin failures++; $display("FAIL midshift_drain step=%0d got=%b exp=%b", k, st_a, 6'b000000); end
      end
      shift_en = 1'b0;
   endtask

`ifdef PISO_SERIAL_IN_EN
   task automatic test_serial_in();
      logic [5:0] exp [6] = '{6'b010100, 6'b010011, 6'b010010, 6'b010001, 6'b101000, 6'b100000};
      load = 1'b1; I = 4'b0000;
      tick();
      load = 1'b0; serial_in = 1'b1; shift_en = 1'b1;
      for (int k = 0; k < 6; k++) begin
         checks++;
         if (st_a !== exp[k]) begin failures++; $display("FAIL serial_in step=%0d got=%b exp=%b", k, st_a, exp[k]); end
         if (k < 5) tick();
      end
      shift_en = 1'b0; serial_in = 1'b0;
   endtask
`endif

   initial begin
      checks    = 0;
      failures  = 0;
      reset     = 1'b1;
      load      = 1'b0;
      I         = '0;
      shift_en  = 1'b0;
      serial_in = 1'b0;
      test_reset();
      test_lsb_word();
      test_msb_word();
      test_stall_reload();
      test_reset_mid_shift();
`ifdef PISO_SERIAL_IN_EN
      test_serial_in();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/piso_shift_reg.md
Name: piso_shift_reg

Overview:
- Parameterised parallel-in, serial-out shift register. Default width is 4 bits.
- Captures a parallel word on load, then shifts it out one bit per clock.
- Provides busy/done status so a serial-link or UART-style transmitter front end can sequence words.
- Sits between a parallel data source and a single-wire serial sink, all in one clock domain.

Parameters:
- N, default 4: data width in bits; legal range is N >= 2.
- MSB_FIRST, default 0: shift order. 0 = LSB first (shift right, serial_out = reg[0]); 1 = MSB first (shift left, serial_out = reg[N-1]).

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-high reset. Clears all state immediately, independent of clk.
- load, input, 1: when high at a clk edge, captures I. Has priority over shifting.
- I, input, N: parallel data word.
- shift_en, input, 1: when high and load is low, shifts by one bit at the clk edge.
- serial_out, output, 1: current output bit, taken directly from the register end bit (no extra register stage).
- busy, output, 1: high while loaded bits remain to be shifted out.
- done, output, 1: one-cycle pulse after the last loaded bit has been shifted out.
- count, output, $clog2(N+1): number of loaded bits still to present, including the bit on serial_out now.

Behaviour:
- Reset asserted: shift register = 0, count = 0, busy = 0, done = 0, serial_out = 0. Reset wins over load and shift_en. Deasserting reset has effect only from the next rising clk edge.
- Load (load=1 at posedge): register <= I, count <= N, busy <= 1, done <= 0. serial_out shows the first bit (I[0], or I[N-1] if MSB_FIRST) right after that edge, with zero-cycle latency.
- Load during busy: aborts the current word and restarts with the new I. No done pulse is produced for the aborted word.
- Shift (load=0, shift_en=1 at posedge):
  - Register moves one position toward the output end.
  - The vacated bit fills with 0 (see Optional Feature).
  - If count > 1: count decrements.
  - If count == 1: count <= 0, busy <= 0, done <= 1 for exactly one cycle.
  - If count == 0: register still shifts (drains zeros), count stays 0, no done pulse.
- Hold (load=0, shift_en=0): register, count and busy keep their values; done <= 0.
- done is high only in the cycle directly after the final shift; every other edge clears it.
- A full word takes N shift cycles after the load edge. The bit presented on serial_out in cycle k (k = 0..N-1) is bit k of I, or bit N-1-k if MSB_FIRST.
- I is sampled only on load edges; I changing at any other time has no effect.
- Widths: count saturates at 0, never wraps. No arithmetic beyond the decrement.

Optional Feature:
- Macro: PISO_SERIAL_IN_EN.
- Defined: adds port serial_in (input, 1). On each shift, the vacated bit takes serial_in instead of 0. This allows cascading several blocks: serial_out of one drives serial_in of the next. count/busy/done behaviour is unchanged.
- Undefined: no serial_in port; fill bit is constant 0.

Test Plan:
- Reset: assert reset mid-clock-period with the register loaded -> serial_out, busy, done and count = 0 immediately, before the next edge. Release reset and hold load=0 -> everything stays 0.
- LSB-first word (N=4, MSB_FIRST=0): load I=4'b1011, then shift_en=1 for 5 cycles.
  - serial_out sequence: 1, 1, 0, 1, 0.
  - count sequence: 4, 3, 2, 1, 0.
  - busy falls and done pulses high for one cycle together after the 4th shift.
- MSB-first word: MSB_FIRST=1, load I=4'b1000, shift 4 cycles -> serial_out sequence 1, 0, 0, 0, then done pulse.
- Stall and reload: load 4'b0110, shift 1 cycle, hold shift_en=0 for 3 cycles -> serial_out stays 1 and count stays 3 during the hold. Then load 4'b1111 -> count = 4, no done pulse, serial_out = 1 for the next 4 shifts.
- Async reset mid-shift: load 4'b1111, shift 2 cycles, pulse reset between edges -> all outputs 0 at once, no done pulse, and further shifts output 0.
- With PISO_SERIAL_IN_EN: load 4'b0000, drive serial_in=1, shift 4 cycles -> register = 4'b1111 and serial_out = 1 from the 4th shift onward.
